// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and elaboration helpers for the configurable UART transmitter.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Clock cycles per bit; integer divide, remainder is dropped.
  function automatic int unsigned calc_ticks(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic bit cfg_legal(input int unsigned data_bits, input int unsigned parity_mode,
                                   input int unsigned stop_bits, input int unsigned fifo_depth,
                                   input int unsigned ticks);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (parity_mode <= PARITY_EVEN) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0) &&
           (ticks >= 2);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready write port carrying one payload word into the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 i_valid;
  logic [DATA_BITS-1:0] i_data;
  logic                 o_ready;

  modport master (output i_valid, output i_data, input o_ready);
  modport slave  (input i_valid, input i_data, output o_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO: RAM storage with registered read port, full/empty flags and occupancy count.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_wr, do_rd;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd)      level_d = level_q + LW'(1);
    else if (!do_wr && do_rd) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage and read register carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
    if (do_rd) rd_data_q     <= mem[rd_ptr_q];
  end

  assign rd_data = rd_data_q;
  assign level   = level_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered word input serialised LSB-first onto o_tx.
// Define UART_TX_BREAK_EN to add the i_break line-break input.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 256
) (
  input  logic                          CLK,
  input  logic                          RST,
  uart_tx_cfg_if.slave                  s_if,
`ifdef UART_TX_BREAK_EN
  input  logic                          i_break,
`endif
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int unsigned TICKS = calc_ticks(CLK_FREQ, BAUD_RATE);
  localparam int unsigned TW    = (TICKS < 2) ? 1 : $clog2(TICKS);
  localparam int unsigned BW    = $clog2(DATA_BITS);

  if (!cfg_legal(DATA_BITS, PARITY_MODE, STOP_BITS, FIFO_DEPTH, TICKS)) begin : g_cfg_err
    $error("uart_tx_cfg: illegal parameter combination");
  end

  tx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 tick_end;
  logic                 brk;

`ifdef UART_TX_BREAK_EN
  assign brk = i_break;
`else
  assign brk = 1'b0;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .wr_en   (s_if.i_valid),
    .wr_data (s_if.i_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_level)
  );

  assign tick_end = (tick_q == TW'(TICKS - 1));

  // Line value and busy are registered from the current state, so the line lags the FSM by one cycle.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = 1'b1;
    busy_d   = 1'b1;
    fifo_pop = 1'b0;
    if (state_q != IDLE) tick_d = tick_end ? '0 : tick_q + TW'(1);
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        tx_d   = !brk;
        if (!fifo_empty && !brk) begin
          fifo_pop = 1'b1;
          state_d  = START;
          tick_d   = '0;
        end
      end
      START: begin
        tx_d = 1'b0;
        // Registered FIFO read data is stable here until the next pop.
        if (tick_end) begin
          state_d = DATA;
          bit_d   = '0;
          shift_d = fifo_rd_data;
          par_d   = (PARITY_MODE == PARITY_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (tick_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        tx_d = par_q;
        if (tick_end) state_d = STOP;
      end
      STOP: begin
        if (tick_end) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!fifo_empty && !brk) begin
              fifo_pop = 1'b1;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign o_tx        = tx_q;
  assign o_busy      = busy_q;
  assign s_if.o_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench: three transmitter configurations compared cycle by cycle against a waveform-queue model.
module tb_uart_tx_cfg;

  localparam int TK    = 10;
  localparam int DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       brk   = 1'b0;
  logic       vin  [3];
  logic [7:0] din  [3];
  logic       tx_o [3];
  logic       busy_o [3];
  logic       rdy_o [3];
  logic [2:0] lvl_o [3];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_b ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_c ();

  assign if_a.i_valid = vin[0];
  assign if_a.i_data  = din[0];
  assign if_b.i_valid = vin[1];
  assign if_b.i_data  = din[1];
  assign if_c.i_valid = vin[2];
  assign if_c.i_data  = din[2];
  assign rdy_o[0] = if_a.o_ready;
  assign rdy_o[1] = if_b.o_ready;
  assign rdy_o[2] = if_c.o_ready;

  // A: 8N1, B: 8E2, C: 8O2; all TICKS=10, FIFO depth 4
  uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY_MODE(0),
                .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
    .CLK(clk), .RST(rst_n), .s_if(if_a),
`ifdef UART_TX_BREAK_EN
    .i_break(brk),
`endif
    .o_tx(tx_o[0]), .o_busy(busy_o[0]), .o_level(lvl_o[0]));

  uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY_MODE(2),
                .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
    .CLK(clk), .RST(rst_n), .s_if(if_b),
`ifdef UART_TX_BREAK_EN
    .i_break(brk),
`endif
    .o_tx(tx_o[1]), .o_busy(busy_o[1]), .o_level(lvl_o[1]));

  uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY_MODE(1),
                .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_c (
    .CLK(clk), .RST(rst_n), .s_if(if_c),
`ifdef UART_TX_BREAK_EN
    .i_break(brk),
`endif
    .o_tx(tx_o[2]), .o_busy(busy_o[2]), .o_level(lvl_o[2]));

  function automatic void chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // Model: per DUT a queue of accepted words and a queue of line values, one per upcoming cycle.
  logic       wave [3][$];
  logic [7:0] mq   [3][$];
  logic       etx  [3];
  logic       ebusy [3];

  function automatic void load_frame(input int d, input logic [7:0] w);
    int   pm;
    int   sb;
    logic pb;
    pm = (d == 0) ? 0 : ((d == 1) ? 2 : 1);
    sb = (d == 0) ? 1 : 2;
    for (int t = 0; t < TK; t++) wave[d].push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int t = 0; t < TK; t++) wave[d].push_back(w[b]);
    if (pm != 0) begin
      pb = (pm == 1) ? ~^w : ^w;
      for (int t = 0; t < TK; t++) wave[d].push_back(pb);
    end
    for (int t = 0; t < sb * TK; t++) wave[d].push_back(1'b1);
  endfunction

  always @(posedge clk) begin : model_cmp
    bit has_word;
    bit near_end;
    bit acc;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        wave[d].delete();
        mq[d].delete();
        etx[d]   = 1'b1;
        ebusy[d] = 1'b0;
      end else begin
        has_word = (mq[d].size() > 0);
        near_end = (wave[d].size() <= 1);
        acc      = vin[d] && (mq[d].size() < DEPTH);
        if (wave[d].size() > 0) begin
          etx[d]   = wave[d].pop_front();
          ebusy[d] = 1'b1;
        end else begin
          etx[d]   = !brk;
          ebusy[d] = 1'b0;
        end
        if (has_word && near_end && !brk) load_frame(d, mq[d].pop_front());
        if (acc) mq[d].push_back(din[d]);
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("tx%0d", d), int'(tx_o[d]), int'(etx[d]));
      chk($sformatf("busy%0d", d), int'(busy_o[d]), int'(ebusy[d]));
      chk($sformatf("level%0d", d), int'(lvl_o[d]), mq[d].size());
      chk($sformatf("ready%0d", d), int'(rdy_o[d]), int'(mq[d].size() != DEPTH));
    end
  end

  task automatic push(input int d, input logic [7:0] w);
    @(negedge clk);
    vin[d] = 1'b1;
    din[d] = w;
    @(posedge clk);
    #1;
    vin[d] = 1'b0;
  endtask

  logic rec_a [1:125];
  logic rec_b [1:125];
  logic rec_c [1:125];
  logic bsy_b [1:125];
  int   busy_cnt;

  initial begin
    for (int d = 0; d < 3; d++) begin
      vin[d] = 1'b0;
      din[d] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx", int'(tx_o[0]), 1);
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_ready", int'(rdy_o[0]), 1);
    chk("rst_level", int'(lvl_o[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 0x55 on 8N1, 0x07 on 8E2 and 8O2, all accepted at the same edge E0
    @(negedge clk);
    vin[0] = 1'b1; din[0] = 8'h55;
    vin[1] = 1'b1; din[1] = 8'h07;
    vin[2] = 1'b1; din[2] = 8'h07;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) vin[d] = 1'b0;
    busy_cnt = 0;
    for (int i = 1; i <= 125; i++) begin
      @(posedge clk);
      #2;
      rec_a[i] = tx_o[0];
      rec_b[i] = tx_o[1];
      rec_c[i] = tx_o[2];
      bsy_b[i] = busy_o[1];
      if (i <= 110) busy_cnt += int'(busy_o[0]);
    end
    chk("lat_e1_high", int'(rec_a[1]), 1);
    chk("lat_e2_start", int'(rec_a[2]), 0);
    chk("start_last", int'(rec_a[11]), 0);
    chk("d0_bit0", int'(rec_a[12]), 1);
    chk("d0_bit1", int'(rec_a[22]), 0);
    chk("d0_bit7", int'(rec_a[82]), 0);
    chk("d0_stop", int'(rec_a[92]), 1);
    chk("busy_100", busy_cnt, 100);
    chk("even_bit0", int'(rec_b[12]), 1);
    chk("even_bit3", int'(rec_b[45]), 0);
    chk("even_parity", int'(rec_b[95]), 1);
    chk("odd_parity", int'(rec_c[95]), 0);
    chk("even_stop2_end", int'(rec_b[121]), 1);
    chk("even_busy_last", int'(bsy_b[121]), 1);
    chk("even_busy_off", int'(bsy_b[122]), 0);

    // FIFO fill: one frame in flight, then six back-to-back pushes into a depth-4 FIFO
    push(0, 8'hA1);
    repeat (2) @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      push(0, 8'(8'hB0 + k));
      if (k == 3) begin
        chk("full_level", int'(lvl_o[0]), 4);
        chk("full_ready", int'(rdy_o[0]), 0);
      end
    end
    chk("drop_level", int'(lvl_o[0]), 4);
    busy_cnt = 0;
    repeat (600) begin
      @(posedge clk);
      #2;
      busy_cnt += int'(busy_o[0]);
    end
    chk("five_frames_busy", busy_cnt, 493);
    chk("drain_level", int'(lvl_o[0]), 0);

    // Push coinciding with the back-to-back pop at level 2
    push(0, 8'hC3);
    push(0, 8'h3C);
    push(0, 8'h96);
    chk("pre_swap_level", int'(lvl_o[0]), 2);
    repeat (98) @(posedge clk);
    push(0, 8'h69);
    chk("swap_level", int'(lvl_o[0]), 2);
    repeat (420) @(posedge clk);
    #2;
    chk("swap_drain_level", int'(lvl_o[0]), 0);
    chk("swap_drain_busy", int'(busy_o[0]), 0);

    // Asynchronous reset in the middle of a data bit
    push(0, 8'h3C);
    push(0, 8'h5A);
    repeat (30) @(posedge clk);
    #3;
    chk("pre_rst_tx", int'(tx_o[0]), 0);
    chk("pre_rst_level", int'(lvl_o[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", int'(tx_o[0]), 1);
    chk("async_rst_level", int'(lvl_o[0]), 0);
    chk("async_rst_busy", int'(busy_o[0]), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0;
    repeat (150) begin
      @(posedge clk);
      #2;
      busy_cnt += int'(busy_o[0]);
    end
    chk("no_residual_frame", busy_cnt, 0);

`ifdef UART_TX_BREAK_EN
    push(0, 8'h0F);
    repeat (20) @(posedge clk);
    @(negedge clk);
    brk = 1'b1;
    push(0, 8'hF0);
    repeat (150) @(posedge clk);
    #2;
    chk("brk_tx", int'(tx_o[0]), 0);
    chk("brk_busy", int'(busy_o[0]), 0);
    chk("brk_level", int'(lvl_o[0]), 1);
    @(negedge clk);
    brk = 1'b0;
    @(posedge clk);
    #2;
    chk("brk_release_tx", int'(tx_o[0]), 1);
    @(posedge clk);
    #2;
    chk("brk_queued_start", int'(tx_o[0]), 0);
    repeat (120) @(posedge clk);
`endif

    repeat (5) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised simplex UART transmitter, next generation of the existing FPGA-to-host serial TX path.
- FIFO-buffered valid/ready byte input; serialises words onto one TX line.
- Configurable data width, parity mode, stop-bit count and FIFO depth.
- Exposes fill level and busy status; FIFO holds exactly FIFO_DEPTH entries with no wasted slot.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; TICKS = CLK_FREQ / BAUD_RATE (integer divide, elaboration error if < 2)
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 256, power of 2, >= 2

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-low
i_valid  in  1  write strobe for i_data
i_data  in  DATA_BITS  payload word, LSB sent first
o_ready  out  1  FIFO not full
o_tx  out  1  serial line, registered, idles high
o_busy  out  1  high while a frame is on the line
o_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Clock and reset: one clock CLK. Reset RST is asynchronous, active-low.
- Reset values: o_tx=1, o_busy=0, o_ready=1, o_level=0. FIFO pointers cleared, FSM=IDLE, tick and bit counters 0.
- Reset asserted mid-frame aborts the frame immediately (o_tx high asynchronously) and discards all FIFO contents.
- Push: i_valid && o_ready at a rising edge stores i_data. When full, o_ready=0 and i_valid is ignored; data is dropped, no error flag.
- o_level: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop. Pointers wrap modulo FIFO_DEPTH.
- o_ready = (o_level != FIFO_DEPTH), combinational from registered level.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_tx=1, o_busy=0. If FIFO non-empty, pop the head word into the shift register at the next edge and enter START.
- Latency: a word pushed into an empty FIFO with FSM in IDLE drives o_tx low at the second edge after the accepting edge.
- START: o_tx=0 for TICKS cycles, then DATA.
- DATA: DATA_BITS bits, each held TICKS cycles, LSB first. Then PARITY if PARITY_MODE != 0, else STOP.
- PARITY: odd mode sends ~^data; even mode sends ^data. Held TICKS cycles.
- STOP: o_tx=1 for STOP_BITS*TICKS cycles. At the end:
  - FIFO non-empty: pop and enter START directly, with no idle cycle between frames.
  - FIFO empty: enter IDLE.
- o_busy is high in START, DATA, PARITY and STOP.
- Tick counter width is $clog2(TICKS). It resets to 0 at every bit boundary, so there is no cumulative drift within a frame.
- Push while the FIFO is empty and the FSM is mid-frame: the word is queued and o_level becomes 1.

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - Adds input i_break (1 bit).
  - While i_break=1 and FSM is IDLE, o_tx is driven 0 (line break) and no pop occurs.
  - If i_break rises mid-frame, the current frame completes first; break starts at the next IDLE.
  - Deassertion returns o_tx to 1 at the next edge.
- Undefined: the port does not exist and no break logic is generated.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/ODD/EVEN constants.
  - tx_state_t enum.
  - Function calc_ticks(clk, baud).
  - Elaboration checks for legal DATA_BITS, STOP_BITS and FIFO_DEPTH.
- Sub-module uart_sync_fifo: width and depth parametrised, full/empty/level outputs, inferred block RAM, registered read.
- Top level holds the FSM, the shift register and the tick/bit counters.

Test Plan:
- CLK_FREQ=1000, BAUD_RATE=100 (TICKS=10), 8N1, push 0x55 -> o_tx low 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high 10 cycles. o_busy high exactly 100 cycles.
- PARITY_MODE=2, STOP_BITS=2, push 0x07 -> parity bit 1, then 20 high cycles. PARITY_MODE=1 with same data -> parity bit 0.
- FIFO_DEPTH=4, push 6 words back-to-back while line busy -> o_ready falls after the 4th word (o_level=4). Words 5-6 dropped. Exactly 4 frames sent with no idle gap between them.
- Simultaneous push and pop at o_level=2 -> o_level stays 2. Final sequence on the line matches push order.
- Assert RST mid DATA state -> o_tx=1 and o_level=0 without waiting for a clock edge. After release, no residual frame is sent.
- UART_TX_BREAK_EN defined: i_break=1 during a frame -> frame completes, then o_tx=0 until i_break=0. A queued word starts one cycle later.
